// File: rtl/credit_pkg.sv
// Shared definitions for the credit-controlled link: debtor FSM encoding
// and elaboration-time parameter sanity helpers.
package credit_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    BACKOFF = 2'd3
  } credit_state_e;

  // The balance must hold a full grant plus one bit of headroom.
  function automatic bit count_width_ok(input int unsigned count_w,
                                        input int unsigned credit_w);
    return count_w >= credit_w + 1;
  endfunction

  // The watermark has to be representable in the balance register.
  function automatic bit watermark_ok(input int unsigned count_w,
                                      input int unsigned watermark);
    return 64'(watermark) < (64'd1 << count_w);
  endfunction

  // A zero-length backoff would let the FSM hammer the creditor.
  function automatic bit backoff_ok(input int unsigned cycles);
    return cycles >= 1;
  endfunction

endpackage

// File: rtl/credit_backoff_timer.sv
// Down-counter used to hold off re-borrowing after a zero-credit grant.
module credit_backoff_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/credit_debtor.sv
// Sender-side credit holder: gates a valid/ready stream on the local
// balance and borrows more credit from the creditor when it runs low.
module credit_debtor
  import credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CREDIT_WIDTH   = 8,
  parameter int unsigned COUNT_WIDTH    = 10,
  parameter int unsigned LOW_WATERMARK  = 4,
  parameter int unsigned BACKOFF_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    borrow,
  input  logic                    grant,
  input  logic [CREDIT_WIDTH-1:0] credit,
  output logic [COUNT_WIDTH-1:0]  balance,
  output logic                    error
);

  localparam int unsigned SUM_W = COUNT_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] WATERMARK = COUNT_WIDTH'(LOW_WATERMARK);

  // Reject parameter sets the balance arithmetic cannot support.
  if (!count_width_ok(COUNT_WIDTH, CREDIT_WIDTH)) begin : g_bad_count_width
    $error("credit_debtor: COUNT_WIDTH must be >= CREDIT_WIDTH+1");
  end
  if (!watermark_ok(COUNT_WIDTH, LOW_WATERMARK)) begin : g_bad_watermark
    $error("credit_debtor: LOW_WATERMARK does not fit in COUNT_WIDTH");
  end
  if (!backoff_ok(BACKOFF_CYCLES)) begin : g_bad_backoff
    $error("credit_debtor: BACKOFF_CYCLES must be >= 1");
  end

  credit_state_e          state_q;
  credit_state_e          state_d;
  logic                   borrow_q;
  logic                   borrow_d;
  logic [COUNT_WIDTH-1:0] balance_q;
  logic [COUNT_WIDTH-1:0] balance_d;
  logic                   error_q;
  logic                   error_d;

  logic                   has_credit_c;
  logic                   xfer_c;
  logic                   capture_c;
  logic                   backoff_load_c;
  logic                   backoff_en_c;
  logic                   backoff_done_c;
  logic [SUM_W-1:0]       sum_c;

  // Zero-latency pass-through, gated on holding at least one credit.
  assign has_credit_c = (balance_q != '0);
  assign out_data     = in_data;
  assign out_valid    = in_valid & has_credit_c;
  assign in_ready     = out_ready & has_credit_c;
  assign xfer_c       = in_valid & out_ready & has_credit_c;

  assign balance = balance_q;
  assign error   = error_q;
  assign borrow  = borrow_q;

  credit_backoff_timer #(
    .CYCLES (BACKOFF_CYCLES)
  ) u_backoff (
    .clk    (clk),
    .rst    (rst),
    .load   (backoff_load_c),
    .en     (backoff_en_c),
    .done_c (backoff_done_c)
  );

  // State register; borrow is registered alongside so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state: one borrow in flight, backoff after an empty grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (balance_q <= WATERMARK) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (grant) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = (credit == '0) ? BACKOFF : IDLE;
      end
      BACKOFF: begin
        if (backoff_done_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM-derived controls for the datapath, timer and borrow flop.
  always_comb begin
    capture_c      = (state_q == CAPTURE);
    backoff_load_c = capture_c && (credit == '0);
    backoff_en_c   = (state_q == BACKOFF);
    borrow_d       = (state_d == REQ);
  end

  // Balance update with one bit of headroom; overflow saturates and sticks.
  always_comb begin
    sum_c     = SUM_W'(balance_q) - SUM_W'(xfer_c)
              + (capture_c ? SUM_W'(credit) : SUM_W'(0));
    balance_d = sum_c[COUNT_WIDTH-1:0];
    error_d   = error_q;
    if (sum_c[COUNT_WIDTH]) begin
      balance_d = '1;
      error_d   = 1'b1;
    end
  end

  // Balance and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      balance_q <= '0;
      error_q   <= 1'b0;
    end else begin
      balance_q <= balance_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: doc/credit_debtor.md
Name: credit_debtor

Overview:
Upstream partner of the credit-granting stage.
- Holds a local credit balance and gates a valid/ready data stream so that one word leaves only when one credit is held.
- Borrows more credit when the balance runs low, using a borrow/grant/credit handshake.
- Sits on the sender side of each GLIP credit-controlled link, feeding the link transmit path.

Parameters:
DATA_WIDTH, 16, width of the gated data word
CREDIT_WIDTH, 8, width of the credit value returned per grant
COUNT_WIDTH, 10, width of the local credit balance; must be >= CREDIT_WIDTH+1
LOW_WATERMARK, 4, a borrow is started when balance <= this value
BACKOFF_CYCLES, 16, idle cycles after a zero-credit grant before borrowing again; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  DATA_WIDTH  upstream data word
in_valid  in  1  upstream word valid
in_ready  out  1  upstream word accepted
out_data  out  DATA_WIDTH  downstream data word
out_valid  out  1  downstream word valid
out_ready  in  1  downstream accepts word
borrow  out  1  credit request to creditor
grant  in  1  creditor accepts request (same cycle as borrow)
credit  in  CREDIT_WIDTH  credit amount; valid exactly one cycle after grant
balance  out  COUNT_WIDTH  current credit balance (registered)
error  out  1  sticky balance-overflow flag

Behaviour:
- Reset (rst=1 at a clk edge): balance=0, state=IDLE, backoff counter=0, error=0.
  - Outputs during/after reset: borrow=0, in_ready=0, out_valid=0.
  - Reset mid-handshake discards any pending credit capture. Credit arriving on the following cycle is ignored.
- Data path is combinational pass-through:
  - out_data = in_data.
  - out_valid = in_valid & (balance != 0).
  - in_ready = out_ready & (balance != 0).
  - xfer = in_valid & out_ready & (balance != 0).
  - No words buffered. Zero latency.
- Balance update each cycle: balance_nxt = balance - xfer + add.
  - add = credit, only in state CAPTURE; otherwise add = 0.
  - Compute in COUNT_WIDTH+1 bits.
  - If the result exceeds 2^COUNT_WIDTH-1: saturate balance at all-ones and set error. error stays set until reset.
- A transfer and a credit capture in the same cycle are both applied: balance - 1 + credit.
- FSM states: IDLE, REQ, CAPTURE, BACKOFF.
  - IDLE: borrow=0. If balance <= LOW_WATERMARK (registered value), go to REQ next cycle.
  - REQ: borrow=1. Stay until grant=1 is seen while borrow=1, then go to CAPTURE. grant outside REQ is ignored.
  - CAPTURE: borrow=0. Sample credit and add it per the update rule. If credit==0, go to BACKOFF; else go to IDLE.
  - BACKOFF: borrow=0. Counter loads BACKOFF_CYCLES-1 on entry and decrements each cycle. Go to IDLE when it reads 0.
- At most one request outstanding. Minimum borrow-to-borrow spacing is 3 cycles: REQ, CAPTURE, IDLE.
- Balance 0 with in_valid=1: out_valid=0, in_ready=0. No word lost.
- Balance saturated: transfers continue normally. error does not block data.

Decomposition:
- Shared package credit_pkg:
  - state encoding enum: IDLE=2'd0, REQ=2'd1, CAPTURE=2'd2, BACKOFF=2'd3.
  - localparam helpers for width checks.
  - Also used by the creditor side for assertions.
- Natural sub-module: credit_backoff_timer, a down-counter with load/done.
- Data gating and the FSM stay in the top module.

Test Plan:
- Reset then idle link: after rst deasserts, borrow=1 on the 2nd cycle. Creditor grants, credit=10 next cycle -> balance=10 one cycle later, state IDLE, no borrow until balance <= 4.
- Streaming: balance=10, in_valid=1, out_ready=1 for 6 cycles -> 6 words out, balance=4, borrow rises the next cycle. Stall-free while credit=20 arrives -> balance reaches 4-k+20 correctly with concurrent decrement.
- Zero grant: credit=0 in CAPTURE -> balance unchanged, BACKOFF for exactly 16 cycles with borrow=0, then IDLE -> REQ again.
- Starvation: balance=0, in_valid=1 -> in_ready=0, out_valid=0 for all cycles until credit arrives. The first word passes the cycle after capture.
- Overflow: COUNT_WIDTH=10, balance=1020, credit=255 -> balance=1023, error=1, error held after further transfers, cleared only by rst.
- Reset mid-handshake: rst in CAPTURE cycle with credit=50 -> balance=0, state IDLE, credit ignored, error=0.
